// File: rtl/sparse_vec_encoder_if.sv
// Handshake bundle between the dense-element producer, the sparse encoder
// and the MVM token consumer. The encoder uses the slave modport; the
// surrounding environment (producer + consumer) uses the master modport.
interface sparse_vec_encoder_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_val;
  logic              out_last;
  logic              out_zero_vec;
  logic [IDX_W:0]    out_nnz;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_val, out_last, out_zero_vec, out_nnz
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_val, out_last, out_zero_vec, out_nnz
  );
endinterface

// File: rtl/sparse_vec_encoder.sv
// Sparse vector encoder: accepts a dense vector one element per cycle,
// drops zeros and emits (index, value) tokens for the nonzero elements.
// One nonzero is held back in a pending slot so the final token of a vector
// can be tagged last together with the vector's nonzero count.
module sparse_vec_encoder #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 3
) (
  input logic                  clk,
  input logic                  rst,
  sparse_vec_encoder_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(VEC_LEN - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic              pend_v_q, pend_v_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic [DATA_W-1:0] pend_val_q, pend_val_d;
  logic [IDX_W:0]    nnz_q, nnz_d;

  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic              out_last_q, out_last_d;
  logic              out_zero_vec_q, out_zero_vec_d;
  logic [IDX_W:0]    out_nnz_q, out_nnz_d;

  logic out_free;
  logic in_ready;
  logic accept;
  logic nonzero;

  // The output slot can take a new token when empty or being drained now.
  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = !rst && (state_q == RUN) && out_free;
  assign accept   = bus.in_valid && in_ready;
  assign nonzero  = |bus.in_data;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_val      = out_val_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_zero_vec = out_zero_vec_q;
  assign bus.out_nnz      = out_nnz_q;

  // Next-state: element intake in RUN, final-token emission in FLUSH.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    pend_v_d       = pend_v_q;
    pend_idx_d     = pend_idx_q;
    pend_val_d     = pend_val_q;
    nnz_d          = nnz_q;
    out_valid_d    = out_valid_q;
    out_idx_d      = out_idx_q;
    out_val_d      = out_val_q;
    out_last_d     = out_last_q;
    out_zero_vec_d = out_zero_vec_q;
    out_nnz_d      = out_nnz_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (accept) begin
          if (nonzero) begin
            nnz_d = nnz_q + (IDX_W+1)'(1);
            if (pend_v_q) begin
              // A newer nonzero proves the pending one is not the last.
              out_valid_d    = 1'b1;
              out_idx_d      = pend_idx_q;
              out_val_d      = pend_val_q;
              out_last_d     = 1'b0;
              out_zero_vec_d = 1'b0;
              out_nnz_d      = '0;
            end
            pend_v_d   = 1'b1;
            pend_idx_d = pos_q;
            pend_val_d = bus.in_data;
          end
          if (pos_q == LAST_POS) begin
            pos_d   = '0;
            state_d = FLUSH;
          end else begin
            pos_d = pos_q + IDX_W'(1);
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          if (pend_v_q) begin
            out_idx_d      = pend_idx_q;
            out_val_d      = pend_val_q;
            out_zero_vec_d = 1'b0;
            out_nnz_d      = nnz_q;
          end else begin
            // All-zero vector still produces one marker token.
            out_idx_d      = '0;
            out_val_d      = '0;
            out_zero_vec_d = 1'b1;
            out_nnz_d      = '0;
          end
          pend_v_d = 1'b0;
          nnz_d    = '0;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control state and output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      pos_q          <= '0;
      pend_v_q       <= 1'b0;
      nnz_q          <= '0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= '0;
      out_val_q      <= '0;
      out_last_q     <= 1'b0;
      out_zero_vec_q <= 1'b0;
      out_nnz_q      <= '0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      pend_v_q       <= pend_v_d;
      nnz_q          <= nnz_d;
      out_valid_q    <= out_valid_d;
      out_idx_q      <= out_idx_d;
      out_val_q      <= out_val_d;
      out_last_q     <= out_last_d;
      out_zero_vec_q <= out_zero_vec_d;
      out_nnz_q      <= out_nnz_d;
    end
  end

  // Pending payload; only meaningful while pend_v_q is set.
  always_ff @(posedge clk) begin
    pend_idx_q <= pend_idx_d;
    pend_val_q <= pend_val_d;
  end

endmodule

// File: tb/tb_sparse_vec_encoder.sv
// Directed testbench for sparse_vec_encoder (VEC_LEN=8, DATA_W=8, IDX_W=3).
module tb_sparse_vec_encoder;

  localparam int VL = 8;
  localparam int DW = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
    logic          last;
    logic          zv;
    logic [IW:0]   nnz;
  } tok_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  tok_t q[$];

  sparse_vec_encoder_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  sparse_vec_encoder #(.VEC_LEN(VL), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back('{bus.out_idx, bus.out_val, bus.out_last, bus.out_zero_vec, bus.out_nnz});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] e, output int acc_cyc);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_data  = e;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_tok(input string tag, input int i, input int idx, input int val,
                         input int last, input int zv, input int nnz);
    tok_t t;
    t = '0;
    if (i < q.size()) t = q[i];
    chk($sformatf("%s_t%0d_idx", tag, i), 32'(t.idx), 32'(idx));
    chk($sformatf("%s_t%0d_val", tag, i), 32'(t.val), 32'(val));
    chk($sformatf("%s_t%0d_last", tag, i), 32'(t.last), 32'(last));
    chk($sformatf("%s_t%0d_zv", tag, i), 32'(t.zv), 32'(zv));
    if (last != 0) chk($sformatf("%s_t%0d_nnz", tag, i), 32'(t.nnz), 32'(nnz));
  endtask

  initial begin
    int t, c0, c1;
    logic [DW-1:0] sparse_v [VL];
    logic [DW-1:0] rst2_v [VL];
    c0 = 0;
    c1 = 0;
    sparse_v = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd3};
    rst2_v   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_zv", 32'(bus.out_zero_vec), 32'd0);
    chk("rst_out_nnz", 32'(bus.out_nnz), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Sparse vector [0,5,0,0,7,0,0,3]
    for (int i = 0; i < VL; i++) push(sparse_v[i], t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sparse_flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("sparse_after_flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("sparse_last_valid", 32'(bus.out_valid), 32'd1);
    idle(3);
    chk("sparse_count", 32'(q.size()), 32'd3);
    chk_tok("sparse", 0, 1, 5, 0, 0, 0);
    chk_tok("sparse", 1, 4, 7, 0, 0, 0);
    chk_tok("sparse", 2, 7, 3, 1, 0, 3);
    q.delete();

    // All-zero vector
    for (int i = 0; i < VL; i++) push(8'd0, t);
    idle(4);
    chk("zero_count", 32'(q.size()), 32'd1);
    chk_tok("zero", 0, 0, 0, 1, 1, 0);
    q.delete();

    // Two dense vectors back to back
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < VL; i++) begin
        push(DW'(i + 1), t);
        if (i == 0) begin
          if (v == 0) c0 = t;
          else c1 = t;
        end
      end
    end
    idle(4);
    chk("dense_period", 32'(c1 - c0), 32'd9);
    chk("dense_count", 32'(q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      chk_tok("dense", k, k % 8, (k % 8) + 1, ((k % 8) == 7) ? 1 : 0, 0, 8);
    q.delete();

    // Backpressure with [9,9,0,0,0,0,0,0]
    bus.out_ready = 1'b0;
    push(8'd9, t);
    push(8'd9, t);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_idx", 32'(bus.out_idx), 32'd0);
      chk("bp_out_val", 32'(bus.out_val), 32'd9);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'd0, t);
    idle(4);
    chk("bp_count", 32'(q.size()), 32'd2);
    chk_tok("bp", 0, 0, 9, 0, 0, 0);
    chk_tok("bp", 1, 1, 9, 1, 0, 2);
    q.delete();

    // Reset mid-vector after [4,0,6]
    push(8'd4, t);
    push(8'd0, t);
    push(8'd6, t);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < VL; i++) push(rst2_v[i], t);
    idle(4);
    chk("midrst_count", 32'(q.size()), 32'd1);
    chk_tok("midrst", 0, 7, 2, 1, 0, 1);
    q.delete();

    // Single nonzero at position 0
    push(8'hFF, t);
    for (int i = 1; i < VL; i++) push(8'd0, t);
    idle(4);
    chk("pos0_count", 32'(q.size()), 32'd1);
    chk_tok("pos0", 0, 0, 255, 1, 0, 1);
    q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
